// File: rtl/cache_alloc_ctrl_pkg.sv
//------------------------------------------------------------------------------
// Module : cache_pkg
// Brief  : Shared types and geometry constants for the 4-set x 4-way cache.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cache_pkg;
  localparam int NUM_SETS = 4;
  localparam int NUM_WAYS = 4;
  localparam int WAY_ID_W = 4;

  typedef logic [1:0]          set_id_t;
  typedef logic [WAY_ID_W-1:0] way_id_t;

  typedef struct packed {
    way_id_t id;
    logic    v;
  } lru_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALLOC = 2'd1,
    EVICT = 2'd2,
    CLEAR = 2'd3
  } alloc_state_e;
endpackage

`default_nettype wire

// File: rtl/cache_alloc_ctrl_free_way_pick.sv
//------------------------------------------------------------------------------
// Module : free_way_pick
// Brief  : Combinational lowest-index free-way finder for one 4-way set.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module free_way_pick
  import cache_pkg::*;
(
  input  logic [NUM_WAYS-1:0] valid_slice,
  output logic                found,
  output logic [1:0]          way_idx
);

  always_comb begin
    found   = 1'b1;
    way_idx = 2'd0;
    if (!valid_slice[0])      way_idx = 2'd0;
    else if (!valid_slice[1]) way_idx = 2'd1;
    else if (!valid_slice[2]) way_idx = 2'd2;
    else if (!valid_slice[3]) way_idx = 2'd3;
    else                      found   = 1'b0;
  end

endmodule

`default_nettype wire

// File: rtl/cache_alloc_ctrl.sv
//------------------------------------------------------------------------------
// Module : cache_alloc_ctrl
// Brief  : Miss-allocation controller owning the per-way valid vector and
//          driving the LRU block; optional stats under `ALLOC_STATS_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cache_alloc_ctrl
  import cache_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         req_valid,
  input  logic [1:0]                   req_set,
  output logic                         req_ready,
  input  logic                         inv_valid,
  input  logic [WAY_ID_W-1:0]          inv_way_id,
  output logic                         alloc_valid,
  output logic [WAY_ID_W-1:0]          alloc_way_id,
  output logic                         evict_err,
  output logic                         lru_wr_en,
  output logic [WAY_ID_W-1:0]          lru_way_id,
  output logic                         lru_full,
  output logic                         valid_vec [NUM_SETS*NUM_WAYS-1:0],
  input  logic [WAY_ID_W:0]            lru_victim1,
  input  logic [WAY_ID_W:0]            lru_victim2
`ifdef ALLOC_STATS_EN
  ,
  output logic [CNT_W-1:0]             stat_alloc,
  output logic [CNT_W-1:0]             stat_evict
`endif
);

  localparam int NUM_ENT = NUM_SETS * NUM_WAYS;

  alloc_state_e         state;
  set_id_t              cur_set;
  logic [NUM_ENT-1:0]   r_valid;

  lru_entry_t           w_v1, w_v2;
  logic                 unused_valid_bits;
  logic [NUM_WAYS-1:0]  w_req_slice, w_cur_slice, w_victim_mask, w_pick_in;
  logic                 w_found;
  logic [1:0]           w_way_idx;
  logic                 w_set_en;
  way_id_t              w_set_idx;
  logic [NUM_ENT-1:0]   w_inv_bits, w_clear_bits, w_set_bits, w_valid_nxt;

  assign w_v1 = lru_victim1;
  assign w_v2 = lru_victim2;
  // The LRU's valid flag carries no information for allocation decisions.
  assign unused_valid_bits = w_v1.v ^ w_v2.v;

  assign w_req_slice = r_valid[{req_set, 2'b00} +: NUM_WAYS];
  assign w_cur_slice = r_valid[{cur_set, 2'b00} +: NUM_WAYS];

  always_comb begin
    w_victim_mask = '0;
    if (w_v1.id[3:2] == cur_set) w_victim_mask[w_v1.id[1:0]] = 1'b1;
    if (w_v2.id[3:2] == cur_set) w_victim_mask[w_v2.id[1:0]] = 1'b1;
  end

  // In CLEAR the victims count as free even before their bits drop.
  assign w_pick_in = (state == CLEAR) ? (w_cur_slice & ~w_victim_mask) : w_req_slice;

  free_way_pick u_pick (
    .valid_slice (w_pick_in),
    .found       (w_found),
    .way_idx     (w_way_idx)
  );

  assign w_set_en  = ((state == IDLE) && req_valid && w_found) ||
                     ((state == CLEAR) && (|w_victim_mask));
  assign w_set_idx = (state == CLEAR) ? {cur_set, w_way_idx} : {req_set, w_way_idx};

  assign w_inv_bits   = inv_valid ? (NUM_ENT'(1) << inv_way_id) : '0;
  assign w_clear_bits = (state == CLEAR) ? (NUM_ENT'(w_victim_mask) << {cur_set, 2'b00}) : '0;
  assign w_set_bits   = w_set_en ? (NUM_ENT'(1) << w_set_idx) : '0;
  // Allocation beats a same-edge invalidate of the same way.
  assign w_valid_nxt  = (r_valid & ~w_inv_bits & ~w_clear_bits) | w_set_bits;

  for (genvar gi = 0; gi < NUM_ENT; gi++) begin : g_valid_out
    assign valid_vec[gi] = r_valid[gi];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cur_set      <= '0;
      r_valid      <= '0;
      req_ready    <= 1'b1;
      alloc_valid  <= 1'b0;
      alloc_way_id <= '0;
      evict_err    <= 1'b0;
      lru_wr_en    <= 1'b0;
      lru_way_id   <= '0;
      lru_full     <= 1'b0;
    end else begin
      r_valid      <= w_valid_nxt;
      alloc_valid  <= 1'b0;
      alloc_way_id <= '0;
      evict_err    <= 1'b0;
      lru_wr_en    <= 1'b0;
      lru_way_id   <= '0;
      lru_full     <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cur_set   <= req_set;
            req_ready <= 1'b0;
            if (w_found) begin
              state        <= ALLOC;
              alloc_valid  <= 1'b1;
              alloc_way_id <= w_set_idx;
              lru_wr_en    <= 1'b1;
              lru_way_id   <= w_set_idx;
            end else begin
              state      <= EVICT;
              lru_full   <= 1'b1;
              lru_way_id <= {req_set, 2'b00};
            end
          end
        end
        EVICT: state <= CLEAR;
        CLEAR: begin
          if (|w_victim_mask) begin
            state        <= ALLOC;
            alloc_valid  <= 1'b1;
            alloc_way_id <= w_set_idx;
            lru_wr_en    <= 1'b1;
            lru_way_id   <= w_set_idx;
          end else begin
            state     <= IDLE;
            req_ready <= 1'b1;
            evict_err <= 1'b1;
          end
        end
        ALLOC: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

`ifdef ALLOC_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_alloc <= '0;
      stat_evict <= '0;
    end else begin
      if (w_set_en && (stat_alloc != '1))       stat_alloc <= stat_alloc + 1'b1;
      if ((state == EVICT) && (stat_evict != '1)) stat_evict <= stat_evict + 1'b1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_cache_alloc_ctrl.sv
//------------------------------------------------------------------------------
// Module : tb_cache_alloc_ctrl
// Brief  : Self-checking bench for cache_alloc_ctrl (timeline model + directed vectors).
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cache_alloc_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_set = 2'd0;
  logic       inv_valid = 1'b0;
  logic [3:0] inv_way_id = 4'd0;
  logic [4:0] lru_victim1 = 5'd0;
  logic [4:0] lru_victim2 = 5'd0;

  logic       req_ready, alloc_valid, evict_err, lru_wr_en, lru_full;
  logic [3:0] alloc_way_id, lru_way_id;
  logic       valid_vec [15:0];
  logic [15:0] dv;
`ifdef ALLOC_STATS_EN
  logic [1:0] stat_alloc, stat_evict;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_alloc_ctrl #(.CNT_W(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_set      (req_set),
    .req_ready    (req_ready),
    .inv_valid    (inv_valid),
    .inv_way_id   (inv_way_id),
    .alloc_valid  (alloc_valid),
    .alloc_way_id (alloc_way_id),
    .evict_err    (evict_err),
    .lru_wr_en    (lru_wr_en),
    .lru_way_id   (lru_way_id),
    .lru_full     (lru_full),
    .valid_vec    (valid_vec),
    .lru_victim1  (lru_victim1),
    .lru_victim2  (lru_victim2)
`ifdef ALLOC_STATS_EN
    ,
    .stat_alloc   (stat_alloc),
    .stat_evict   (stat_evict)
`endif
  );

  always_comb begin
    dv = '0;
    for (int i = 0; i < 16; i++) dv[i] = valid_vec[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lowest_zero(input logic [3:0] s);
    for (int k = 0; k < 4; k++) if (!s[k]) return k;
    return -1;
  endfunction

  // Model: "left" = cycles until the controller is free again after an accept.
  logic [15:0] m_valid = '0;
  int          left = 0;
  logic [1:0]  m_set = '0;
  logic        e_alloc = 0, e_err = 0, e_full = 0, e_wr = 0;
  logic [3:0]  e_id = '0, e_lid = '0;
  logic [1:0]  m_sa = '0, m_se = '0;
  logic        e_ready;
  assign e_ready = (left == 0);

  always @(posedge clk or posedge reset) begin : model
    logic [15:0] nv;
    logic [3:0]  sl, vm;
    int          w;
    if (reset) begin
      m_valid <= '0; left <= 0; e_alloc <= 0; e_err <= 0; e_full <= 0; e_wr <= 0;
      e_id <= '0; e_lid <= '0; m_sa <= '0; m_se <= '0;
    end else begin
      nv = m_valid;
      if (inv_valid) nv[inv_way_id] = 1'b0;
      e_alloc <= 0; e_err <= 0; e_full <= 0; e_wr <= 0; e_id <= '0; e_lid <= '0;
      if (left == 0) begin
        if (req_valid) begin
          m_set <= req_set;
          sl = m_valid[req_set*4 +: 4];
          w  = lowest_zero(sl);
          if (w >= 0) begin
            nv[req_set*4 + w] = 1'b1;
            e_alloc <= 1; e_wr <= 1;
            e_id <= 4'(req_set*4 + w); e_lid <= 4'(req_set*4 + w);
            left <= 1;
            if (m_sa != 2'd3) m_sa <= m_sa + 2'd1;
          end else begin
            e_full <= 1; e_lid <= 4'(req_set*4);
            left <= 3;
          end
        end
      end else if (left == 3) begin
        left <= 2;
        if (m_se != 2'd3) m_se <= m_se + 2'd1;
      end else if (left == 2) begin
        vm = '0;
        if (lru_victim1[4:3] == m_set) vm[lru_victim1[2:1]] = 1'b1;
        if (lru_victim2[4:3] == m_set) vm[lru_victim2[2:1]] = 1'b1;
        sl = m_valid[m_set*4 +: 4];
        for (int k = 0; k < 4; k++) if (vm[k]) nv[m_set*4 + k] = 1'b0;
        if (vm != 0) begin
          w = lowest_zero(sl & ~vm);
          nv[m_set*4 + w] = 1'b1;
          e_alloc <= 1; e_wr <= 1;
          e_id <= 4'(m_set*4 + w); e_lid <= 4'(m_set*4 + w);
          left <= 1;
          if (m_sa != 2'd3) m_sa <= m_sa + 2'd1;
        end else begin
          e_err <= 1;
          left <= 0;
        end
      end else begin
        left <= 0;
      end
      m_valid <= nv;
    end
  end

  always @(negedge clk) begin
    check("req_ready", req_ready, e_ready);
    check("alloc_valid", alloc_valid, e_alloc);
    if (e_alloc) check("alloc_way_id", alloc_way_id, e_id);
    check("lru_wr_en", lru_wr_en, e_wr);
    check("lru_full", lru_full, e_full);
    if (e_wr || e_full) check("lru_way_id", lru_way_id, e_lid);
    check("evict_err", evict_err, e_err);
    check("valid_vec", dv, m_valid);
    check("wr_and_full", lru_wr_en & lru_full, 0);
`ifdef ALLOC_STATS_EN
    check("stat_alloc", stat_alloc, m_sa);
    check("stat_evict", stat_evict, m_se);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] s);
    req_valid = 1'b1;
    req_set   = s;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    repeat (2) step();
    check("rst_ready", req_ready, 1);
    check("rst_vvec", dv, 0);
    reset = 1'b0;
    step();

    // 1: free way in set 1
    req(2'd1);
    check("t1_alloc", alloc_valid, 1);
    check("t1_id", alloc_way_id, 4'h4);
    check("t1_wr", lru_wr_en, 1);
    check("t1_v4", dv[4], 1);
    step();

    // 2: fill set 2, then evict victims 8 and 9
    for (int i = 0; i < 4; i++) begin
      req(2'd2);
      check("t2_fill_id", alloc_way_id, 32'(8 + i));
      step();
    end
    lru_victim1 = {4'h8, 1'b1};
    lru_victim2 = {4'h9, 1'b1};
    req(2'd2);
    check("t2_full", lru_full, 1);
    check("t2_full_id", lru_way_id, 4'h8);
    step();
    check("t2_clear_noalloc", alloc_valid, 0);
    step();
    check("t2_alloc", alloc_valid, 1);
    check("t2_id", alloc_way_id, 4'h8);
    check("t2_v9", dv[9], 0);
    step();

    // 3: victims in the wrong set
    for (int i = 0; i < 4; i++) begin
      req(2'd0);
      check("t3_fill_id", alloc_way_id, 32'(i));
      step();
    end
    lru_victim1 = {4'h5, 1'b1};
    lru_victim2 = {4'h6, 1'b1};
    req(2'd0);
    step();
    step();
    check("t3_err", evict_err, 1);
    check("t3_noalloc", alloc_valid, 0);
    check("t3_set0", dv[3:0], 4'hf);
    step();
    check("t3_err_pulse", evict_err, 0);

    // 4: invalidate vs allocate on the same edge, then invalidate during ALLOC
    inv_valid = 1'b1; inv_way_id = 4'd3;
    step();
    check("t4_v3_clr", dv[3], 0);
    req(2'd0);
    inv_way_id = 4'd2;
    check("t4_id", alloc_way_id, 4'h3);
    check("t4_v3_set", dv[3], 1);
    step();
    inv_valid = 1'b0;
    check("t4_v2_clr", dv[2], 0);

    // 5: reset during CLEAR
    for (int i = 0; i < 4; i++) begin
      req(2'd3);
      check("t5_fill_id", alloc_way_id, 32'(12 + i));
      step();
    end
    lru_victim1 = {4'hC, 1'b1};
    lru_victim2 = {4'hD, 1'b1};
    req(2'd3);
    step();
    reset = 1'b1;
    #1;
    check("t5_rst_vvec", dv, 0);
    check("t5_rst_ready", req_ready, 1);
    check("t5_rst_alloc", alloc_valid, 0);
    step();
    reset = 1'b0;
    step();
    check("t5_noalloc", alloc_valid, 0);
    req(2'd3);
    check("t5_id", alloc_way_id, 4'hC);
    step();

    // inv during EVICT to the target set; duplicate victims
    for (int i = 0; i < 4; i++) begin
      req(2'd1);
      step();
    end
    lru_victim1 = {4'h6, 1'b1};
    lru_victim2 = {4'h6, 1'b1};
    req(2'd1);
    inv_valid = 1'b1; inv_way_id = 4'h5;
    step();
    inv_valid = 1'b0;
    step();
    check("t7_id", alloc_way_id, 4'h5);
    check("t7_v6", dv[6], 0);
    step();

`ifdef ALLOC_STATS_EN
    check("t6_stat_alloc", stat_alloc, 2'd3);
    check("t6_stat_evict", stat_evict, 2'd1);
`endif
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
